mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a 4-input, WIDTH-bit multiplexer datapath among four requesters and drives its select. Each requester raises a request with its data, and the block grants one requester at a time. It presents the selected word on a valid/ready output port and acknowledges the winner on each accepted transfer. It sits in front of the multiplexer_4to1 datapath and replaces the free-running select with fair, handshaked sequencing.

---
 rtl/mux4_rr_arbiter_if.sv | 34 +++
 rtl/mux4_rr_arbiter.sv | 103 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Requester, output-handshake and mux-select bundle for mux4_rr_arbiter.
// When MUX_ARB_LOCK_EN is defined, a lock bit for multi-word bursts is added.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 4);
   logic [3:0]       req;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] in3;
   logic [3:0]       ack;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;
   logic             busy;
`ifdef MUX_ARB_LOCK_EN
   logic             lock;
`endif

   modport master (
      output req, in0, in1, in2, in3, out_ready,
`ifdef MUX_ARB_LOCK_EN
      output lock,
`endif
      input  ack, out_valid, out_data, out_sel, busy
   );

   modport slave (
      input  req, in0, in1, in2, in3, out_ready,
`ifdef MUX_ARB_LOCK_EN
      input  lock,
`endif
      output ack, out_valid, out_data, out_sel, busy
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, valid/ready output, 1-cycle req-to-valid.
// Build option MUX_ARB_LOCK_EN: lock input keeps the grant (no rotation) across burst transfers.
module mux4_rr_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  bus
);
   typedef enum logic {IDLE, GRANT} state_e;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic             valid_w;
   logic             xfer_w;
   logic             lock_w;
   logic [3:0]       ack_w;
   logic [3:0]       cand_w;
   logic [2:0]       pick_w;
   logic [WIDTH-1:0] mux_dat;

   // Returns {found, index}; the lowest offset from p wins, so it is written last.
   function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] p);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (c[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

`ifdef MUX_ARB_LOCK_EN
   assign lock_w = bus.lock;
`else
   assign lock_w = 1'b0;
`endif

   assign valid_w = (state_q == GRANT) && bus.req[sel_q];
   assign xfer_w  = valid_w && bus.out_ready;
   assign ack_w   = xfer_w ? (4'b0001 << sel_q) : 4'b0000;

   always_comb begin
      mux_dat = bus.in0;
      case (sel_q)
         2'd0: mux_dat = bus.in0;
         2'd1: mux_dat = bus.in1;
         2'd2: mux_dat = bus.in2;
         2'd3: mux_dat = bus.in3;
      endcase
   end

   assign bus.out_data  = mux_dat;
   assign bus.out_valid = valid_w;
   assign bus.ack       = ack_w;
   assign bus.out_sel   = sel_q;
   assign bus.busy      = (state_q == GRANT);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cand_w  = 4'b0000;
      pick_w  = 3'b000;
      case (state_q)
         IDLE: begin
            pick_w = rr_pick(bus.req, ptr_q);
            if (pick_w[2]) begin
               sel_d   = pick_w[1:0];
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (xfer_w) begin
               if (!lock_w) begin
                  // The just-served requester is masked so a lone repeat requester takes one bubble.
                  ptr_d  = sel_q + 2'd1;
                  cand_w = bus.req & ~ack_w;
                  pick_w = rr_pick(cand_w, sel_q + 2'd1);
                  if (pick_w[2]) sel_d = pick_w[1:0];
                  else           state_d = IDLE;
               end
            end else if (!bus.req[sel_q]) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
      end
   end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against a cycle-level round-robin reference model.
module tb_mux4_rr_arbiter;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux4_rr_arbiter_if #(.WIDTH(W)) bus ();
   mux4_rr_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [3:0]   r;
   logic         rdy;
   logic         lk;
   logic [W-1:0] word [4];
   int           cnt  [4];

   // Reference: granted flag, current selection, rotating priority start.
   bit m_grant;
   int m_sel;
   int m_ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [3:0] c, input int p);
      for (int k = 0; k < 4; k++)
         if (c[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic apply();
      bus.req = r;
      bus.in0 = word[0];
      bus.in1 = word[1];
      bus.in2 = word[2];
      bus.in3 = word[3];
      bus.out_ready = rdy;
`ifdef MUX_ARB_LOCK_EN
      bus.lock = lk;
`endif
   endtask

   task automatic model_reset();
      m_grant = 0;
      m_sel   = 0;
      m_ptr   = 0;
   endtask

   // One clock: check outputs mid-low-phase, advance model at posedge, return at negedge.
   task automatic cycle(output logic [3:0] acked);
      bit v, x;
      logic [3:0] ae;
      int w;
      apply();
      #1;
      v  = m_grant && r[m_sel];
      x  = v && rdy;
      ae = x ? 4'(1 << m_sel) : 4'b0000;
      chk("out_valid", 32'(bus.out_valid), 32'(v));
      chk("ack",       32'(bus.ack),       32'(ae));
      chk("busy",      32'(bus.busy),      32'(m_grant));
      chk("out_sel",   32'(bus.out_sel),   32'(m_sel));
      chk("out_data",  32'(bus.out_data),  32'(word[m_sel]));
      acked = bus.ack;
      @(posedge clk);
      if (!m_grant) begin
         w = first_from(r, m_ptr);
         if (w >= 0) begin m_sel = w; m_grant = 1; end
      end else if (x) begin
         if (!lk) begin
            m_ptr = (m_sel + 1) % 4;
            w = first_from(r & ~ae, m_ptr);
            if (w >= 0) m_sel = w;
            else        m_grant = 0;
         end
      end else if (!r[m_sel]) begin
         m_grant = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      r = 4'b0000; rdy = 1'b0; lk = 1'b0;
      apply();
      rst_n = 1'b0;
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   logic [3:0] a;
   logic [3:0] exp_seq [5];

   initial begin
      r = 4'b0000; rdy = 1'b0; lk = 1'b0;
      for (int i = 0; i < 4; i++) begin word[i] = W'(i + 1); cnt[i] = 0; end
      model_reset();
      apply();
      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ack",       32'(bus.ack),       32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'(word[0]));
      @(negedge clk);
      rst_n = 1'b1;

      // Single request on requester 2.
      r = 4'b0100; word[2] = 4'h9; rdy = 1'b1;
      cycle(a);
      cycle(a);
      chk("single_ack", 32'(a), 32'b0100);
      r = 4'b0000;
      cycle(a);
      // ptr is now 3: requesters 1 and 3 compete, 3 must win.
      r = 4'b1010;
      cycle(a);
      cycle(a);
      chk("ptr3_winner", 32'(a), 32'b1000);
      r = 4'b0000;
      cycle(a);

      // All four requesting from reset.
      do_reset();
      r = 4'b1111; rdy = 1'b1;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      cycle(a);
      for (int i = 0; i < 5; i++) begin
         cycle(a);
         chk("rr_order", 32'(a), 32'(exp_seq[i]));
      end
      r = 4'b0000;
      cycle(a);

      // Backpressure on requester 1.
      do_reset();
      r = 4'b0010; rdy = 1'b0;
      cycle(a);
      for (int i = 0; i < 5; i++) begin
         cycle(a);
         chk("bp_no_ack", 32'(a), 32'd0);
      end
      rdy = 1'b1;
      cycle(a);
      chk("bp_release_ack", 32'(a), 32'b0010);
      r = 4'b0000;
      cycle(a);

      // Withdrawal of requester 3, then requester 0 is served.
      do_reset();
      r = 4'b1000; rdy = 1'b0;
      cycle(a);
      cycle(a);
      r = 4'b0001;
      cycle(a);
      chk("wd_no_ack", 32'(a), 32'd0);
      cycle(a);
      rdy = 1'b1;
      cycle(a);
      chk("wd_req0_ack", 32'(a), 32'b0001);
      r = 4'b0000;
      cycle(a);

      // Asynchronous reset while a grant is valid.
      r = 4'b0100; rdy = 1'b0; word[2] = 4'h5;
      cycle(a);
      cycle(a);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rdy = 1'b1;
      apply();
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_ack",       32'(bus.ack),       32'd0);
      chk("arst_busy",      32'(bus.busy),      32'd0);
      chk("arst_out_sel",   32'(bus.out_sel),   32'd0);
      chk("arst_out_data",  32'(bus.out_data),  32'(word[0]));
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      r = 4'b0000; rdy = 1'b0;
      cycle(a);

`ifdef MUX_ARB_LOCK_EN
      // Locked burst on requester 2, then an unlocked final word.
      do_reset();
      r = 4'b0101; rdy = 1'b1; lk = 1'b1;
      cycle(a);
      cycle(a);
      chk("lock_first_ack", 32'(a), 32'b0001);
      r = 4'b0100;
      cycle(a);
      cycle(a);
      for (int i = 0; i < 3; i++) begin
         cycle(a);
         chk("lock_burst_ack", 32'(a), 32'b0100);
      end
      lk = 1'b0;
      cycle(a);
      chk("lock_release_ack", 32'(a), 32'b0100);
      r = 4'b1010;
      cycle(a);
      cycle(a);
      chk("lock_ptr3_winner", 32'(a), 32'b1000);
      r = 4'b0000;
      cycle(a);
`endif

      // Randomized traffic: multi-word requesters, random backpressure and withdrawals.
      do_reset();
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int n = 0; n < 800; n++) begin
         rdy = ($urandom_range(3) != 0);
         cycle(a);
         for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
               cnt[i]--;
               word[i] = W'($urandom);
            end else if (cnt[i] > 0 && $urandom_range(39) == 0) begin
               cnt[i] = 0;
            end
            if (cnt[i] == 0 && $urandom_range(3) == 0) begin
               cnt[i]  = 1 + $urandom_range(2);
               word[i] = W'($urandom);
            end
            r[i] = (cnt[i] > 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
